// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER pipeline hazard controller.
//   opcode_t     RV32I major opcodes seen by the hazard decoders
//   func3_t      branch func3 encodings
//   hz_state_t   interrupt-entry sequencer states
//   NOP_INSTR_DEFAULT  bubble instruction (addi x0,x0,0)
//   ST_*         stage indices used for the per-stage decode arrays
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } func3_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TAKE  = 2'd2
    } hz_state_t;

    localparam int ST_DEC = 0;
    localparam int ST_EXE = 1;
    localparam int ST_MEM = 2;
    localparam int ST_WB  = 3;
    localparam int N_ST   = 4;

endpackage

// File: rtl/hazard_src_decode.sv
// Register-usage decoder for one pipeline stage IR.
//   ir_i        instruction held in the stage
//   rs1_o/rs2_o source register fields
//   rd_o        destination register field
//   uses_rs1_o  instruction reads rs1
//   uses_rs2_o  instruction reads rs2
//   writes_rd_o instruction writes a non-x0 destination
//   is_load_o   instruction is a LOAD writing a non-x0 destination
// The bubble instruction is reported as touching no registers at all, so a
// flushed slot can never stall the pipe even if BUBBLE is not a canonical NOP.
module hazard_src_decode
    import otter_pkg::*;
#(
    parameter logic [31:0] BUBBLE = NOP_INSTR_DEFAULT
) (
    input  logic [31:0] ir_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic        writes_rd_o,
    output logic        is_load_o
);

    opcode_t op;
    logic    wr;
    logic    ld;

    assign op    = opcode_t'(ir_i[6:0]);
    assign rs1_o = ir_i[19:15];
    assign rs2_o = ir_i[24:20];
    assign rd_o  = ir_i[11:7];

    always_comb begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b0;
        wr         = 1'b0;
        ld         = 1'b0;
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                uses_rs1_o = 1'b0;
                wr         = 1'b1;
            end
            OPC_JALR, OPC_OP_IMM: wr = 1'b1;
            OPC_LOAD: begin
                wr = 1'b1;
                ld = 1'b1;
            end
            OPC_OP: begin
                uses_rs2_o = 1'b1;
                wr         = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: uses_rs2_o = 1'b1;
            // ecall/ebreak/mret (func3=0) write nothing; CSR ops write rd
            OPC_SYSTEM: wr = (ir_i[14:12] != 3'b000);
            default: ;
        endcase

        if (ir_i == BUBBLE) begin
            uses_rs1_o = 1'b0;
            uses_rs2_o = 1'b0;
            wr         = 1'b0;
            ld         = 1'b0;
        end

        // x0 is hardwired zero: writing it never produces a dependency
        writes_rd_o = wr && (rd_o != 5'd0);
        is_load_o   = ld && (rd_o != 5'd0);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage OTTER core (IF/DEC/EXE/MEM/WB).
//   CLK, RST              clock, asynchronous active-high reset
//   DEC_IR..WB_IR         stage instruction registers
//   BR_TAKEN              control transfer taken in EXE
//   MEM_BUSY              data memory not ready, freeze everything
//   INTR, CSR_MIE         interrupt request (level) and global enable
//   PC_EN, *_IR_EN        per-stage load enables
//   DEC_FLUSH, EXE_FLUSH  load the bubble instruction instead of the upstream IR
//   INT_TAKEN             one-cycle pulse: redirect to mtvec, save DEC PC
//   FWD_A, FWD_B          rs1/rs2 bypass select: 0 RF, 1 MEM, 2 WB
// Optional feature: define HAZARD_FWD_EN to enable bypass selects; only
// load-use then stalls. Without it every RAW dependency on EXE/MEM/WB stalls.
// All outputs are combinational from the current state and inputs.
module pipeline_hazard_ctrl
    import otter_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] DEC_IR,
    input  logic [31:0] EXE_IR,
    input  logic [31:0] MEM_IR,
    input  logic [31:0] WB_IR,
    input  logic        BR_TAKEN,
    input  logic        MEM_BUSY,
    input  logic        INTR,
    input  logic        CSR_MIE,
    output logic        PC_EN,
    output logic        DEC_IR_EN,
    output logic        EXE_IR_EN,
    output logic        MEM_IR_EN,
    output logic        WB_IR_EN,
    output logic        DEC_FLUSH,
    output logic        EXE_FLUSH,
    output logic        INT_TAKEN,
    output logic [1:0]  FWD_A,
    output logic [1:0]  FWD_B
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] ir       [N_ST];
    logic [4:0]  rs1      [N_ST];
    logic [4:0]  rs2      [N_ST];
    logic [4:0]  rd       [N_ST];
    logic        uses_rs1 [N_ST];
    logic        uses_rs2 [N_ST];
    logic        wr       [N_ST];
    logic        ld       [N_ST];

    logic        stall;
    logic [1:0]  fwd_a, fwd_b;

    assign ir[ST_DEC] = DEC_IR;
    assign ir[ST_EXE] = EXE_IR;
    assign ir[ST_MEM] = MEM_IR;
    assign ir[ST_WB]  = WB_IR;

    for (genvar g = 0; g < N_ST; g++) begin : g_dec
        hazard_src_decode #(
            .BUBBLE(NOP_INSTR)
        ) u_dec (
            .ir_i       (ir[g]),
            .rs1_o      (rs1[g]),
            .rs2_o      (rs2[g]),
            .rd_o       (rd[g]),
            .uses_rs1_o (uses_rs1[g]),
            .uses_rs2_o (uses_rs2[g]),
            .writes_rd_o(wr[g]),
            .is_load_o  (ld[g])
        );
    end

    // Only the DEC consumer fields and the older-stage producer fields matter.
    logic unused_decode;
    assign unused_decode = ^{rd[ST_DEC], wr[ST_DEC], ld[ST_DEC], ld[ST_EXE],
                             ld[ST_MEM], ld[ST_WB],
                             rs1[ST_EXE], rs1[ST_MEM], rs1[ST_WB],
                             rs2[ST_EXE], rs2[ST_MEM], rs2[ST_WB],
                             uses_rs1[ST_EXE], uses_rs1[ST_MEM], uses_rs1[ST_WB],
                             uses_rs2[ST_EXE], uses_rs2[ST_MEM], uses_rs2[ST_WB]};

    function automatic logic hits(input logic [4:0] src, input logic used,
                                  input logic [4:0] dst, input logic writes);
        return used && writes && (src == dst);
    endfunction

    always_comb begin
`ifdef HAZARD_FWD_EN
        // A load in EXE has no data until the end of MEM: hold DEC one cycle
        stall = hits(rs1[ST_DEC], uses_rs1[ST_DEC], rd[ST_EXE], ld[ST_EXE]) ||
                hits(rs2[ST_DEC], uses_rs2[ST_DEC], rd[ST_EXE], ld[ST_EXE]);

        // Youngest producer wins: MEM before WB
        if (hits(rs1[ST_DEC], uses_rs1[ST_DEC], rd[ST_MEM], wr[ST_MEM]))
            fwd_a = 2'd1;
        else if (hits(rs1[ST_DEC], uses_rs1[ST_DEC], rd[ST_WB], wr[ST_WB]))
            fwd_a = 2'd2;
        else
            fwd_a = 2'd0;

        if (hits(rs2[ST_DEC], uses_rs2[ST_DEC], rd[ST_MEM], wr[ST_MEM]))
            fwd_b = 2'd1;
        else if (hits(rs2[ST_DEC], uses_rs2[ST_DEC], rd[ST_WB], wr[ST_WB]))
            fwd_b = 2'd2;
        else
            fwd_b = 2'd0;
`else
        // RF is written at the clock edge, so a WB producer still blocks DEC
        stall = hits(rs1[ST_DEC], uses_rs1[ST_DEC], rd[ST_EXE], wr[ST_EXE]) ||
                hits(rs1[ST_DEC], uses_rs1[ST_DEC], rd[ST_MEM], wr[ST_MEM]) ||
                hits(rs1[ST_DEC], uses_rs1[ST_DEC], rd[ST_WB],  wr[ST_WB])  ||
                hits(rs2[ST_DEC], uses_rs2[ST_DEC], rd[ST_EXE], wr[ST_EXE]) ||
                hits(rs2[ST_DEC], uses_rs2[ST_DEC], rd[ST_MEM], wr[ST_MEM]) ||
                hits(rs2[ST_DEC], uses_rs2[ST_DEC], rd[ST_WB],  wr[ST_WB]);
        fwd_a = 2'd0;
        fwd_b = 2'd0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        PC_EN     = 1'b0;
        DEC_IR_EN = 1'b0;
        EXE_IR_EN = 1'b0;
        MEM_IR_EN = 1'b0;
        WB_IR_EN  = 1'b0;
        DEC_FLUSH = 1'b0;
        EXE_FLUSH = 1'b0;
        INT_TAKEN = 1'b0;
        FWD_A     = 2'd0;
        FWD_B     = 2'd0;

        if (!RST) begin
            FWD_A = fwd_a;
            FWD_B = fwd_b;
        end

        if (RST || MEM_BUSY) begin
            // frozen: enables and flushes stay low, FSM and counter hold
        end else begin
            // Everything downstream of DEC always advances when not frozen
            EXE_IR_EN = 1'b1;
            MEM_IR_EN = 1'b1;
            WB_IR_EN  = 1'b1;
            case (state_q)
                TAKE: begin
                    PC_EN     = 1'b1;
                    DEC_IR_EN = 1'b1;
                    DEC_FLUSH = 1'b1;
                    EXE_FLUSH = 1'b1;
                    INT_TAKEN = 1'b1;
                    state_d   = RUN;
                end
                DRAIN: begin
                    if (BR_TAKEN) begin
                        // a draining instruction redirected: abandon entry,
                        // the request is arbitrated again from RUN
                        PC_EN     = 1'b1;
                        DEC_IR_EN = 1'b1;
                        DEC_FLUSH = 1'b1;
                        EXE_FLUSH = 1'b1;
                        state_d   = RUN;
                    end else begin
                        EXE_FLUSH = 1'b1;
                        if (cnt_q == '0)
                            state_d = TAKE;
                        else
                            cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (BR_TAKEN) begin
                        PC_EN     = 1'b1;
                        DEC_IR_EN = 1'b1;
                        DEC_FLUSH = 1'b1;
                        EXE_FLUSH = 1'b1;
                    end else if (stall) begin
                        EXE_FLUSH = 1'b1;
                    end else begin
                        PC_EN     = 1'b1;
                        DEC_IR_EN = 1'b1;
                        if (INTR && CSR_MIE) begin
                            state_d = DRAIN;
                            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] DEC_IR = 32'h13, EXE_IR = 32'h13, MEM_IR = 32'h13, WB_IR = 32'h13;
    logic        BR_TAKEN = 1'b0, MEM_BUSY = 1'b0, INTR = 1'b0, CSR_MIE = 1'b0;
    logic        PC_EN, DEC_IR_EN, EXE_IR_EN, MEM_IR_EN, WB_IR_EN;
    logic        DEC_FLUSH, EXE_FLUSH, INT_TAKEN;
    logic [1:0]  FWD_A, FWD_B;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .NOP_INSTR(32'h0000_0013)) dut (
        .CLK(CLK), .RST(RST),
        .DEC_IR(DEC_IR), .EXE_IR(EXE_IR), .MEM_IR(MEM_IR), .WB_IR(WB_IR),
        .BR_TAKEN(BR_TAKEN), .MEM_BUSY(MEM_BUSY), .INTR(INTR), .CSR_MIE(CSR_MIE),
        .PC_EN(PC_EN), .DEC_IR_EN(DEC_IR_EN), .EXE_IR_EN(EXE_IR_EN),
        .MEM_IR_EN(MEM_IR_EN), .WB_IR_EN(WB_IR_EN),
        .DEC_FLUSH(DEC_FLUSH), .EXE_FLUSH(EXE_FLUSH), .INT_TAKEN(INT_TAKEN),
        .FWD_A(FWD_A), .FWD_B(FWD_B)
    );

    always #5 CLK = ~CLK;

    // {PC,DEC,EXE,MEM,WB enables, DEC_FLUSH, EXE_FLUSH, INT_TAKEN, FWD_A, FWD_B}
    logic [11:0] got;
    assign got = {PC_EN, DEC_IR_EN, EXE_IR_EN, MEM_IR_EN, WB_IR_EN,
                  DEC_FLUSH, EXE_FLUSH, INT_TAKEN, FWD_A, FWD_B};

    localparam logic [11:0] NORM  = 12'b11111_00_0_00_00;
    localparam logic [11:0] STALL = 12'b00111_01_0_00_00;
    localparam logic [11:0] BRF   = 12'b11111_11_0_00_00;
    localparam logic [11:0] FROZE = 12'b00000_00_0_00_00;
    localparam logic [11:0] TAKEV = 12'b11111_11_1_00_00;
    localparam logic [11:0] ZERO  = 12'b0;

    typedef struct packed {
        logic [31:0] dec, exe, mem, wb;
        logic br, busy, intr, mie;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [11:0] nf;  // expected without bypassing
        logic [11:0] fw;  // expected with bypassing
    } tvec_t;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1,
                                        input int rs2, input int f3);
        return {7'd0, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic stim_t st(input logic [31:0] d, input logic [31:0] e,
                                 input logic [31:0] m, input logic [31:0] w,
                                 input logic br, input logic busy,
                                 input logic intr, input logic mie);
        stim_t s;
        s.dec = d; s.exe = e; s.mem = m; s.wb = w;
        s.br = br; s.busy = busy; s.intr = intr; s.mie = mie;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        DEC_IR = s.dec; EXE_IR = s.exe; MEM_IR = s.mem; WB_IR = s.wb;
        BR_TAKEN = s.br; MEM_BUSY = s.busy; INTR = s.intr; CSR_MIE = s.mie;
    endtask

    // one clock: new inputs shortly after the rising edge, sample on the falling edge
    task automatic cyc(input stim_t s, input logic rst);
        @(posedge CLK);
        #1;
        drive(s);
        RST = rst;
        @(negedge CLK);
    endtask

    task automatic check(input string nm, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Register usage is read straight off the instruction fields; 0 means "none",
    // which is safe because x0 never carries a dependency.
    function automatic logic [4:0] dst_of(input logic [31:0] ir);
        case (ir[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: return ir[11:7];
            7'h73:   return (ir[14:12] != 3'd0) ? ir[11:7] : 5'd0;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] srca_of(input logic [31:0] ir);
        if (ir[6:0] == 7'h37 || ir[6:0] == 7'h17 || ir[6:0] == 7'h6F) return 5'd0;
        return ir[19:15];
    endfunction

    function automatic logic [4:0] srcb_of(input logic [31:0] ir);
        if (ir[6:0] == 7'h33 || ir[6:0] == 7'h23 || ir[6:0] == 7'h63) return ir[24:20];
        return 5'd0;
    endfunction

    function automatic logic [1:0] bypass(input logic [4:0] src, input stim_t s);
        if (src == 5'd0)          return 2'd0;
        if (dst_of(s.mem) == src) return 2'd1;
        if (dst_of(s.wb) == src)  return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic needs_stall(input stim_t s);
        logic [4:0] a, b;
        a = srca_of(s.dec);
        b = srcb_of(s.dec);
`ifdef HAZARD_FWD_EN
        if (s.exe[6:0] != 7'h03 || dst_of(s.exe) == 5'd0) return 1'b0;
        return (dst_of(s.exe) == a) || (dst_of(s.exe) == b);
`else
        return (a != 0 && (a == dst_of(s.exe) || a == dst_of(s.mem) || a == dst_of(s.wb))) ||
               (b != 0 && (b == dst_of(s.exe) || b == dst_of(s.mem) || b == dst_of(s.wb)));
`endif
    endfunction

    // interrupt entry progress: 0 running, 1 draining (m_left cycles after this one), 2 taking
    int m_phase = 0;
    int m_left  = 0;

    function automatic logic [11:0] m_expect(input stim_t s, input logic rst);
        logic [3:0] fwd;
        if (rst) return ZERO;
`ifdef HAZARD_FWD_EN
        fwd = {bypass(srca_of(s.dec), s), bypass(srcb_of(s.dec), s)};
`else
        fwd = 4'd0;
`endif
        if (s.busy)                         return FROZE | {8'd0, fwd};
        if (m_phase == 2)                   return TAKEV | {8'd0, fwd};
        if (s.br)                           return BRF   | {8'd0, fwd};
        if (m_phase == 1 || needs_stall(s)) return STALL | {8'd0, fwd};
        return NORM | {8'd0, fwd};
    endfunction

    task automatic m_step(input stim_t s, input logic rst);
        if (rst) begin
            m_phase = 0;
        end else if (!s.busy) begin
            if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (s.br)             m_phase = 0;
                else if (m_left == 0) m_phase = 2;
                else                  m_left--;
            end else if (!s.br && !needs_stall(s) && s.intr && s.mie) begin
                m_phase = 1;
                m_left  = DRAIN - 1;
            end
        end
    endtask

    // ---------------- test ----------------
    tvec_t tbl[17];

    initial begin
        logic [31:0] NOP, ADD, ADDI_X1, LW_X1, LUI_X0, LUI_X2, LUI_X1, LUI4_R1;
        logic [31:0] ADDI5_12, SW_12, ADDI_X2, SW_RD1, CSRRW_X1, ECALL_RD1;
        stim_t s;
        logic  r;

        NOP       = 32'h0000_0013;
        ADD       = enc(7'h33, 3, 1, 2, 0);
        ADDI_X1   = enc(7'h13, 1, 0, 0, 0);
        LW_X1     = enc(7'h03, 1, 5, 0, 2);
        LUI_X0    = enc(7'h37, 0, 1, 1, 0);
        LUI_X2    = enc(7'h37, 2, 0, 0, 0);
        LUI_X1    = enc(7'h37, 1, 0, 0, 0);
        LUI4_R1   = enc(7'h37, 4, 1, 1, 0);
        ADDI5_12  = enc(7'h13, 5, 1, 2, 0);
        SW_12     = enc(7'h23, 0, 1, 2, 2);
        ADDI_X2   = enc(7'h13, 2, 0, 0, 0);
        SW_RD1    = enc(7'h23, 1, 0, 0, 2);
        CSRRW_X1  = enc(7'h73, 1, 0, 0, 1);
        ECALL_RD1 = enc(7'h73, 1, 0, 0, 0);

        tbl[0]  = '{st(NOP, NOP, NOP, NOP, 0, 0, 0, 0),                 NORM,  NORM};
        tbl[1]  = '{st(ADD, ADDI_X1, NOP, NOP, 0, 0, 0, 0),             STALL, NORM};
        tbl[2]  = '{st(ADD, NOP, ADDI_X1, NOP, 0, 0, 0, 0),             STALL, NORM | 12'b01_00};
        tbl[3]  = '{st(ADD, NOP, NOP, LUI_X2, 0, 0, 0, 0),              STALL, NORM | 12'b00_10};
        tbl[4]  = '{st(ADD, LUI_X0, LUI_X0, LUI_X0, 0, 0, 0, 1),        NORM,  NORM};
        tbl[5]  = '{st(ADD, LW_X1, NOP, NOP, 1, 0, 0, 0),               BRF,   BRF};
        tbl[6]  = '{st(ADD, ADDI_X1, NOP, NOP, 0, 1, 0, 0),             FROZE, FROZE};
        tbl[7]  = '{st(LUI4_R1, ADDI_X1, ADDI_X1, ADDI_X1, 0, 0, 0, 0), NORM,  NORM};
        tbl[8]  = '{st(ADDI5_12, LUI_X2, LUI_X2, LUI_X2, 0, 0, 0, 0),   NORM,  NORM};
        tbl[9]  = '{st(SW_12, NOP, NOP, ADDI_X2, 0, 0, 0, 0),           STALL, NORM | 12'b00_10};
        tbl[10] = '{st(ADD, SW_RD1, SW_RD1, SW_RD1, 0, 0, 0, 0),        NORM,  NORM};
        tbl[11] = '{st(ADD, CSRRW_X1, NOP, NOP, 0, 0, 0, 0),            STALL, NORM};
        tbl[12] = '{st(ADD, ECALL_RD1, ECALL_RD1, ECALL_RD1, 0, 0, 0, 0), NORM, NORM};
        tbl[13] = '{st(ADD, LW_X1, NOP, NOP, 0, 0, 0, 0),               STALL, STALL};
        tbl[14] = '{st(ADD, NOP, LUI_X1, LUI_X1, 0, 0, 0, 0),           STALL, NORM | 12'b01_00};
        tbl[15] = '{st(ADD, NOP, LUI_X1, LUI_X2, 0, 0, 0, 0),           STALL, NORM | 12'b01_10};
        tbl[16] = '{st(ADD, ADDI_X1, NOP, NOP, 1, 1, 0, 0),             FROZE, FROZE};

        // reset holds everything low even with requests pending
        drive(st(ADD, ADDI_X1, NOP, NOP, 1, 0, 1, 1));
        #2;
        check("reset_outputs", ZERO);

        // single-cycle combinations from RUN (no interrupt request)
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].s, 1'b0);
`ifdef HAZARD_FWD_EN
            check($sformatf("tbl%0d", i), tbl[i].fw);
`else
            check($sformatf("tbl%0d", i), tbl[i].nf);
`endif
        end

        // RAW dependency as the producer moves down the pipe
`ifdef HAZARD_FWD_EN
        cyc(st(ADD, LW_X1, NOP, NOP, 0, 0, 0, 0), 1'b0);   check("lduse_c0", STALL);
        cyc(st(ADD, NOP, LW_X1, NOP, 0, 0, 0, 0), 1'b0);   check("lduse_c1", NORM | 12'b01_00);
`else
        cyc(st(ADD, ADDI_X1, NOP, NOP, 0, 0, 0, 0), 1'b0); check("raw_c0", STALL);
        cyc(st(ADD, NOP, ADDI_X1, NOP, 0, 0, 0, 0), 1'b0); check("raw_c1", STALL);
        cyc(st(ADD, NOP, NOP, ADDI_X1, 0, 0, 0, 0), 1'b0); check("raw_c2", STALL);
        cyc(st(ADD, NOP, NOP, NOP, 0, 0, 0, 0), 1'b0);     check("raw_c3", NORM);
`endif
        // branch over a load-use hazard, then no stall
        cyc(st(ADD, LW_X1, NOP, NOP, 1, 0, 0, 0), 1'b0);   check("br_lduse", BRF);
        cyc(st(NOP, NOP, LW_X1, NOP, 0, 0, 0, 0), 1'b0);   check("br_after", NORM);

        // interrupt entry: enter, drain DRAIN cycles, one TAKE pulse
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("int_enter", NORM);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("int_drain0", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("int_drain1", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("int_take", TAKEV);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("int_after", NORM);

        // MEM_BUSY inside DRAIN delays the pulse; request dropped mid-drain still completes
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("busy_enter", NORM);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("busy_drain0", STALL);
        for (int i = 0; i < 3; i++) begin
            cyc(st(NOP, NOP, NOP, NOP, 0, 1, 0, 1), 1'b0); check($sformatf("busy_hold%0d", i), FROZE);
        end
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("busy_drain1", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("busy_take", TAKEV);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("busy_after", NORM);

        // branch during DRAIN abandons entry; request re-arbitrated from RUN
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("brd_enter", NORM);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("brd_drain", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 1, 0, 1, 1), 1'b0);     check("brd_branch", BRF);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("brd_reenter", NORM);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("brd_drain0", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("brd_drain1", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("brd_take", TAKEV);

        // a stall blocks entry; the request waits for a clean cycle
        cyc(st(ADD, LW_X1, NOP, NOP, 0, 0, 1, 1), 1'b0);   check("stl_block", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("stl_enter", NORM);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("stl_drain0", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("stl_drain1", STALL);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("stl_take", TAKEV);

        // masked request never enters
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 0), 1'b0);     check("masked0", NORM);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 0), 1'b0);     check("masked1", NORM);

        // short asynchronous reset pulse between edges while draining
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 1, 1), 1'b0);     check("rst_enter", NORM);
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0);     check("rst_drain", STALL);
        #1 RST = 1'b1;
        #1 check("rst_pulse", ZERO);
        #1 RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 1), 1'b0); check($sformatf("rst_after%0d", i), NORM);
        end

        // randomized traffic against the reference model
        cyc(st(NOP, NOP, NOP, NOP, 0, 0, 0, 0), 1'b1);
        m_phase = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] ops[11];
            ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};
            s.dec  = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 10)]};
            s.exe  = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 10)]};
            s.mem  = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 10)]};
            s.wb   = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 10)]};
            s.br   = ($urandom_range(0, 99) < 15);
            s.busy = ($urandom_range(0, 99) < 15);
            s.intr = ($urandom_range(0, 99) < 40);
            s.mie  = ($urandom_range(0, 99) < 70);
            r      = ($urandom_range(0, 99) < 2);
            cyc(s, r);
            check($sformatf("rand%0d", i), m_expect(s, r));
            m_step(s, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
